// File: rtl/pipe_pkg.sv
// Shared constants and beat type for the fetch/decode pipeline register slice.
package pipe_pkg;

    localparam int unsigned BEAT_PC_W   = 32;
    localparam int unsigned BEAT_DATA_W = 32;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [BEAT_PC_W-1:0]   pc;
        logic [BEAT_DATA_W-1:0] data;
    } beat_t;

    function automatic logic [1:0] nextCount(input logic [1:0] count, input logic push,
                                             input logic pop);
        return count + 2'(push) - 2'(pop);
    endfunction

endpackage

// File: rtl/pipe_stage_if.sv
// Valid/ready beat channel carrying {pc, data}; master drives the beat, slave drives ready.
interface pipe_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 32
);
    logic              valid;
    logic              ready;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;

    modport master (output valid, pc, data, input ready);
    modport slave  (input valid, pc, data, output ready);
endinterface

// File: rtl/pipe_skid_buf.sv
// Two-entry FIFO backing the pipe_stage skid buffer; head is read combinationally.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] pushData,
    input  logic         pop,
    output logic [W-1:0] popData,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wrPtr;
    logic         rdPtr;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wrPtr <= 1'b0;
            rdPtr <= 1'b0;
            count <= '0;
        end else begin
            if (push) wrPtr <= ~wrPtr;
            if (pop)  rdPtr <= ~rdPtr;
            count <= nextCount(count, push, pop);
        end
    end

    // Storage needs no reset: empty masks the head at the top level.
    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= pushData;
    end

    assign popData = mem[rdPtr];
    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);

endmodule

// File: rtl/pipe_stage.sv
// Pipeline register slice with flush/stall; define PIPE_STAGE_SKID_EN for a 2-entry
// skid buffer with registered in-ready, otherwise a single entry with combinational ready.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       PC_W     = 32,
    parameter logic [PC_W-1:0]   RESET_PC = PC_W'(RESET_PC_DEF),
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             stall,
    pipe_stage_if.slave      inBus,
    pipe_stage_if.master     outBus,
    output logic [1:0]       occupancy
);

`ifdef PIPE_STAGE_SKID_EN

    logic [PC_W+DATA_W-1:0] headBits;
    logic                   full;
    logic                   empty;
    logic [1:0]             count;
    logic                   push;
    logic                   pop;
    logic                   readyReg;

    assign inBus.ready = reset & ~stall & readyReg;
    assign push        = inBus.valid & inBus.ready & ~flush & ~full;
    assign pop         = ~empty & outBus.ready & ~stall & ~flush;

    pipe_skid_buf #(
        .W (PC_W + DATA_W)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .push     (push),
        .pushData ({inBus.pc, inBus.data}),
        .pop      (pop),
        .popData  (headBits),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    // Ready is computed from next-cycle occupancy so out_ready never reaches in_ready.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            readyReg <= 1'b1;
        end else begin
            readyReg <= (nextCount(count, push, pop) < 2'd2);
        end
    end

    assign outBus.valid = ~empty;
    assign outBus.pc    = empty ? RESET_PC : headBits[PC_W+DATA_W-1:DATA_W];
    assign outBus.data  = empty ? NOP_WORD : headBits[DATA_W-1:0];
    assign occupancy    = count;

`else

    logic              validReg;
    logic [PC_W-1:0]   pcReg;
    logic [DATA_W-1:0] dataReg;
    logic              accept;
    logic              retire;

    assign inBus.ready = reset & ~stall & (~validReg | outBus.ready);
    assign accept      = inBus.valid & inBus.ready;
    assign retire      = validReg & outBus.ready & ~stall;

    // Held registers are reloaded with bubble values whenever the entry empties.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            validReg <= 1'b0;
            pcReg    <= RESET_PC;
            dataReg  <= NOP_WORD;
        end else if (!stall) begin
            if (accept) begin
                validReg <= 1'b1;
                pcReg    <= inBus.pc;
                dataReg  <= inBus.data;
            end else if (retire) begin
                validReg <= 1'b0;
                pcReg    <= RESET_PC;
                dataReg  <= NOP_WORD;
            end
        end
    end

    assign outBus.valid = validReg;
    assign outBus.pc    = pcReg;
    assign outBus.data  = dataReg;
    assign occupancy    = {1'b0, validReg};

`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboard bench for pipe_stage; follows PIPE_STAGE_SKID_EN to pick the capacity model.
module tb_pipe_stage;
    import pipe_pkg::*;

`ifdef PIPE_STAGE_SKID_EN
    localparam int unsigned CAP = 2;
`else
    localparam int unsigned CAP = 1;
`endif

    localparam logic [31:0] BUB_PC   = 32'h8000_0000;
    localparam logic [31:0] BUB_DATA = 32'h0000_0000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       flush = 1'b0;
    logic       stall = 1'b0;
    logic [1:0] occupancy;

    pipe_stage_if #(.DATA_W(32), .PC_W(32)) inBus ();
    pipe_stage_if #(.DATA_W(32), .PC_W(32)) outBus ();

    pipe_stage #(
        .DATA_W   (32),
        .PC_W     (32),
        .RESET_PC (32'h8000_0000),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .stall     (stall),
        .inBus     (inBus),
        .outBus    (outBus),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int unsigned nChecks = 0;
    int unsigned nFails  = 0;
    logic        armed = 1'b0;
    logic        lastAccept = 1'b0;
    beat_t       sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares outputs against the scoreboard, then applies this cycle's edge.
    always @(negedge clk) begin
        if (armed) begin
            logic  expReady;
            logic  expValid;
            logic  acc;
            beat_t head;
            expValid = (sb.size() != 0);
            if (CAP == 2)
                expReady = reset && !stall && (sb.size() < 2);
            else
                expReady = reset && !stall && (sb.size() == 0 || outBus.ready);
            head = expValid ? sb[0] : '{pc: BUB_PC, data: BUB_DATA};
            chk("in_ready",  {31'd0, inBus.ready},  {31'd0, expReady});
            chk("out_valid", {31'd0, outBus.valid}, {31'd0, expValid});
            chk("occupancy", {30'd0, occupancy},    32'(sb.size()));
            chk("out_pc",    outBus.pc,   head.pc);
            chk("out_data",  outBus.data, head.data);
            acc = 1'b0;
            if (!reset || flush) begin
                sb.delete();
            end else if (!stall) begin
                acc = inBus.valid && expReady;
                if (expValid && outBus.ready) void'(sb.pop_front());
                if (acc) sb.push_back('{pc: inBus.pc, data: inBus.data});
            end
            lastAccept = acc;
        end
    end

    task automatic step(input logic v, input logic [31:0] p, input logic [31:0] d,
                        input logic ordy, input logic st, input logic fl);
        inBus.valid  = v;
        inBus.pc     = p;
        inBus.data   = d;
        outBus.ready = ordy;
        stall        = st;
        flush        = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] p, input logic [31:0] d, input logic ordy);
        int unsigned n = 0;
        do begin
            step(1'b1, p, d, ordy, 1'b0, 1'b0);
            n++;
        end while (!lastAccept && n < 20);
        nChecks++;
        if (!lastAccept) begin
            nFails++;
            $display("FAIL offer_timeout: beat pc=%h not accepted in %0d cycles", p, n);
        end
    endtask

    initial begin
        inBus.valid  = 1'b0;
        inBus.pc     = '0;
        inBus.data   = '0;
        outBus.ready = 1'b0;

        // Reset held low for two edges, then checked before release
        @(posedge clk); #1;
        @(posedge clk); #1;
        armed = 1'b1;
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;

        // 8-beat stream with a always-ready consumer
        for (int i = 0; i < 8; i++)
            step(1'b1, 32'(4 * (i + 1)), 32'h1000_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Backpressure with three offered beats, then drain
        step(1'b1, 32'h0000_0100, 32'hA000_0001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0104, 32'hA000_0002, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0108, 32'hA000_0003, 1'b0, 1'b0, 1'b0);
        offer(32'h0000_0108, 32'hA000_0003, 1'b1);
        repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush at full occupancy with a beat offered
        step(1'b1, 32'h0000_0200, 32'hB000_0001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0204, 32'hB000_0002, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hDEAD_0000, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
        repeat (2) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Stall for three cycles with a beat held and consumer ready
        step(1'b1, 32'h0000_0300, 32'hC000_0001, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b1, 32'h0000_0304, 32'hC000_0002, 1'b1, 1'b1, 1'b0);
        repeat (2) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush and stall together
        step(1'b1, 32'h0000_0400, 32'hD000_0001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0404, 32'hD000_0002, 1'b1, 1'b1, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Mid-transfer reset
        step(1'b1, 32'h0000_0500, 32'hE000_0001, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step(1'b1, 32'h0000_0504, 32'hE000_0002, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        step(1'b1, 32'h0000_0508, 32'hE000_0003, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) != 0);
            step(($urandom_range(0, 2) != 0), $urandom, $urandom,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 29) == 0));
        end
        reset = 1'b1;
        repeat (4) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter DATA_W, default 32: instruction/payload width in bits.
REQ-002 Parameter PC_W, default 32: PC field width in bits.
REQ-003 Parameter RESET_PC, default 32'h80000000: PC value presented on reset, flush and bubble.
REQ-004 Parameter NOP_WORD, default 32'h00000000: payload value presented on reset, flush and bubble.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 flush  in  1  discards all held and incoming beats.
REQ-008 stall  in  1  freezes the stage and blocks acceptance.
REQ-009 in_valid  in  1  upstream beat present.
REQ-010 in_ready  out  1  stage accepts a beat this cycle.
REQ-011 in_pc  in  PC_W  upstream PC+4.
REQ-012 in_data  in  DATA_W  upstream instruction.
REQ-013 out_valid  out  1  downstream beat present.
REQ-014 out_ready  in  1  downstream consumes the beat.
REQ-015 out_pc  out  PC_W  held PC+4.
REQ-016 out_data  out  DATA_W  held instruction.
REQ-017 occupancy  out  2  number of held beats (0..2).

Function
REQ-018 An input beat SHALL be accepted iff in_valid & in_ready at a rising edge; an output beat SHALL retire iff out_valid & out_ready.
REQ-019 Accept-to-out_valid latency SHALL be exactly 1 cycle when the stage is empty.
REQ-020 Beats SHALL leave in acceptance order, unmodified.
REQ-021 Whenever out_valid=0, out_pc SHALL equal RESET_PC and out_data SHALL equal NOP_WORD (bubble).
REQ-022 stall=1 SHALL force in_ready=0, SHALL hold out_valid/out_pc/out_data/occupancy unchanged, and SHALL block retirement even if out_ready=1.
REQ-023 flush=1 SHALL, at the next edge, set occupancy=0 and out_valid=0; any beat offered in that cycle SHALL be discarded.
REQ-024 Priority SHALL be reset > flush > stall > normal transfer.
REQ-025 Simultaneous accept and retire at occupancy 1 SHALL leave occupancy 1, with the new beat on the outputs.
REQ-026 occupancy SHALL never exceed 1 without PIPE_STAGE_SKID_EN, nor 2 with it.

Reset
REQ-027 reset=0 at an edge SHALL set out_valid=0, occupancy=0, out_pc=RESET_PC, out_data=NOP_WORD, and in_ready=0 while reset is low.
REQ-028 Reset mid-transfer SHALL drop all held beats; the first acceptance is possible on the first edge after reset is released.

Configuration
REQ-029 Macro PIPE_STAGE_SKID_EN defined: a 2-entry skid buffer is built; in_ready SHALL be a registered signal equal to (occupancy<2) & ~stall, sustaining one beat per cycle with no combinational path from out_ready to in_ready.
REQ-030 Macro PIPE_STAGE_SKID_EN undefined: single entry; in_ready SHALL be the combinational signal ~stall & (~out_valid | out_ready).

Structure
REQ-031 Package pipe_pkg SHALL hold the RESET_PC and NOP_WORD default constants and the beat typedef {pc, data}.
REQ-032 The skid storage SHALL be sub-module pipe_skid_buf (2-entry FIFO, full/empty flags), instantiated only under PIPE_STAGE_SKID_EN.

Verification
REQ-033 Reset low for 2 cycles -> out_valid=0, out_pc=32'h80000000, out_data=32'h00000000, occupancy=0.
REQ-034 Stream of 8 beats (pc 4,8,...,32; data 32'h1000_0000+i) with out_ready=1 -> identical sequence out, 1-cycle latency, one beat per cycle.
REQ-035 (SKID_EN) out_ready=0 while 3 beats are offered -> 2 accepted, occupancy=2, in_ready=0 on the next cycle; out_ready=1 -> both drain in order, then the third is accepted.
REQ-036 Occupancy 2 with flush=1 and in_valid=1 -> next cycle occupancy=0, out_valid=0, bubble values on the outputs, offered beat never appears.
REQ-037 stall=1 for 3 cycles with a beat held and out_ready=1 -> outputs frozen, in_ready=0; after stall drops the beat retires once.
REQ-038 flush=1 and stall=1 together -> flush wins; stage is empty next cycle.
